pri_enc_reg: RTL and testbench
==============================

PRI_ENC_REG -- requirements
Module: pri_enc_reg

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i, input, 4 bits: the word to encode; bit 3 has highest priority.
REQ-005 The block SHALL have port in_valid, input, 1 bit: i is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept i this cycle.
REQ-007 The block SHALL have port y, output, 2 bits: the encoded index of the highest set bit of the accepted word.
REQ-008 The block SHALL have port out_valid, output, 1 bit: y, err and zero hold a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result this cycle.
REQ-010 The block SHALL have port err, output, 1 bit: the accepted word had more than one bit set.
REQ-011 The block SHALL have port zero, output, 1 bit: the accepted word was 4'b0000.
REQ-012 The block SHALL have port err_cnt, output, CNT_W bits: a saturating count of accepted words that were not one-hot.

Function
REQ-013 Encoding SHALL be: highest set bit 3 gives y=11, bit 2 gives y=10, bit 1 gives y=01, bit 0 gives y=00, and i=0000 gives y=00 with zero=1.
REQ-014 err SHALL be 1 iff the accepted word has two or more bits set; y SHALL still encode the highest set bit in that case.
REQ-015 zero and err SHALL never be 1 simultaneously.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 The block SHALL be a one-entry registered stage: y, err, zero and out_valid are registers, and latency from input transfer to out_valid is exactly 1 cycle.
REQ-018 in_ready SHALL be combinational and equal to (!out_valid || out_ready).
REQ-019 The control FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 In EMPTY, an input transfer SHALL load the result and move the FSM to FULL; with no input transfer the FSM SHALL stay in EMPTY.
REQ-021 In FULL with out_ready=0, the FSM SHALL stay in FULL, and y, err and zero SHALL be held stable regardless of i and in_valid.
REQ-022 In FULL with out_ready=1 and an input transfer (simultaneous drain and fill), the FSM SHALL load the new result and stay in FULL, with no bubble.
REQ-023 In FULL with out_ready=1 and no input transfer, the FSM SHALL move to EMPTY.
REQ-024 In EMPTY, y, err and zero SHALL retain their last values; downstream SHALL ignore them while out_valid=0.
REQ-025 err_cnt SHALL increment by 1 on each input transfer whose word has err=1 or zero=1.
REQ-026 err_cnt SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-027 err_cnt SHALL update at the same edge the result is loaded.
REQ-028 i SHALL not be sampled while in_valid=0.

Reset
REQ-029 While rst=1, regardless of clk: out_valid=0, y=00, err=0, zero=0, err_cnt=0, and the FSM SHALL be in EMPTY.
REQ-030 Assertion of rst during FULL SHALL discard the held result, and no output transfer SHALL be reported for it.
REQ-031 After rst deasserts, in_ready SHALL be 1, and the first input transfer SHALL be accepted at the first rising edge at which it is presented.

Verification
REQ-032 One-hot sweep: present i=0001, 0010, 0100, 1000 back-to-back with out_ready=1 -> y=00, 01, 10, 11 on consecutive cycles, each one cycle after its input transfer; err=0; err_cnt=0.
REQ-033 Multi-hot and zero words: present i=1010, then 0000, then 0111 -> y=11 with err=1, then y=00 with zero=1, then y=10 with err=1; err_cnt=3.
REQ-034 Backpressure: accept i=0100, then hold out_ready=0 for 3 cycles while i=0001 with in_valid=1 -> in_ready=0 and y=10 held stable; when out_ready rises, 0001 is accepted on that same edge and y=00 appears the next cycle.
REQ-035 Saturation: with CNT_W=2, accept five words of 0000 -> err_cnt reads 1, 2, 3, 3, 3.
REQ-036 Reset mid-operation: assert rst asynchronously while FULL holds y=11 -> out_valid=0 and err_cnt=0 immediately, without waiting for a clock edge; after release, i=0010 gives y=01 one cycle after its input transfer.

Source files
------------

// File: rtl/pri_enc_reg.sv
// 4-bit priority encoder behind a one-entry valid/ready register stage.
// Flags multi-hot and all-zero words and keeps a saturating count of them.
module pri_enc_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             zero,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_y;
  logic             r_err;
  logic             r_zero;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_xfer;
  logic             w_load;
  logic [1:0]       w_y;
  logic             w_err;
  logic             w_zero;

  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_in_xfer = in_valid && in_ready;

  always_comb begin
    w_y    = 2'b00;
    w_err  = 1'b0;
    w_zero = 1'b0;
    casez (i)
      4'b1???: w_y = 2'b11;
      4'b01??: w_y = 2'b10;
      4'b001?: w_y = 2'b01;
      default: w_y = 2'b00;
    endcase
    w_zero = (i == 4'b0000);
    // Two or more bits set: clearing the lowest set bit leaves something.
    w_err  = ((i & (i - 4'd1)) != 4'b0000);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_load      = 1'b1;
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (w_in_xfer) begin
            w_load      = 1'b1;
            w_state_nxt = FULL;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y    <= 2'b00;
      r_err  <= 1'b0;
      r_zero <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_y    <= w_y;
      r_err  <= w_err;
      r_zero <= w_zero;
      if ((w_err || w_zero) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign y       = r_y;
  assign err     = r_err;
  assign zero    = r_zero;
  assign err_cnt = r_cnt;

endmodule

// File: tb/tb_pri_enc_reg.sv
// Directed bench for pri_enc_reg: default-width instance plus a CNT_W=2
// instance on shared stimulus for counter saturation.
module tb_pri_enc_reg;

  logic       clk;
  logic       rst;
  logic [3:0] i;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready,  in_ready2;
  logic [1:0] y,         y2;
  logic       out_valid, out_valid2;
  logic       err,       err2;
  logic       zero,      zero2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int errors = 0;
  int checks = 0;

  pri_enc_reg dut (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready), .err(err),
    .zero(zero), .err_cnt(err_cnt)
  );

  pri_enc_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .in_ready(in_ready2),
    .y(y2), .out_valid(out_valid2), .out_ready(out_ready), .err(err2),
    .zero(zero2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int ev, input int ey,
                         input int ee, input int ez);
    chk({tag, ".out_valid"}, int'(out_valid), ev);
    chk({tag, ".y"},         int'(y),         ey);
    chk({tag, ".err"},       int'(err),       ee);
    chk({tag, ".zero"},      int'(zero),      ez);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [3:0] onehot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [7:0] sat8   [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  logic [1:0] sat2   [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst       = 1'b1;
    i         = 4'b0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.err_cnt", int'(err_cnt), 0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_reset.in_ready", int'(in_ready), 1);

    // One-hot sweep, back to back.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i = onehot[k];
      step();
      chk_out($sformatf("onehot%0d", k), 1, k, 0, 0);
      chk($sformatf("onehot%0d.err_cnt", k), int'(err_cnt), 0);
    end
    in_valid = 1'b0;
    i = 4'b0110;
    step();
    chk("drain.out_valid", int'(out_valid), 0);
    chk("drain.y_retained", int'(y), 3);
    step();
    chk("idle.y_retained", int'(y), 3);

    // Multi-hot and zero words.
    in_valid = 1'b1;
    i = 4'b1010;
    step();
    chk_out("multi1010", 1, 3, 1, 0);
    chk("multi1010.err_cnt", int'(err_cnt), 1);
    i = 4'b0000;
    step();
    chk_out("zero0000", 1, 0, 0, 1);
    chk("zero0000.err_cnt", int'(err_cnt), 2);
    i = 4'b0111;
    step();
    chk_out("multi0111", 1, 2, 1, 0);
    chk("multi0111.err_cnt", int'(err_cnt), 3);
    chk("multi0111.err_cnt2", int'(err_cnt2), 3);
    in_valid = 1'b0;
    step();

    // Backpressure.
    i = 4'b0100;
    in_valid = 1'b1;
    step();
    chk_out("bp_load", 1, 2, 0, 0);
    out_ready = 1'b0;
    i = 4'b0001;
    #1;
    chk("bp.in_ready", int'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("bp_hold%0d", k), 1, 2, 0, 0);
      chk($sformatf("bp_hold%0d.in_ready", k), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", int'(in_ready), 1);
    step();
    chk_out("bp_accept", 1, 0, 0, 0);
    in_valid = 1'b0;
    step();
    chk("bp.err_cnt", int'(err_cnt), 3);

    // Saturation.
    do_reset();
    #1;
    chk("sat_reset.err_cnt2", int'(err_cnt2), 0);
    i = 4'b0000;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("sat%0d.err_cnt2", k), int'(err_cnt2), int'(sat2[k]));
      chk($sformatf("sat%0d.err_cnt", k),  int'(err_cnt),  int'(sat8[k]));
    end
    in_valid = 1'b0;
    step();

    // Asynchronous reset while FULL.
    i = 4'b1000;
    in_valid = 1'b1;
    step();
    chk_out("pre_rst", 1, 3, 0, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    chk("async_rst.err_cnt", int'(err_cnt), 0);
    chk("async_rst.err_cnt2", int'(err_cnt2), 0);
    rst = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    i = 4'b0010;
    #1;
    chk("after_rst.in_ready", int'(in_ready), 1);
    step();
    chk_out("after_rst", 1, 1, 0, 0);
    chk("after_rst.y2", int'(y2), 1);
    in_valid = 1'b0;
    step();
    chk("final.out_valid", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
